hw_ctrl: RTL and testbench

HW_CTRL -- requirements
Module: hw_ctrl

---
 rtl/hw_ctrl.sv | 141 ++++++++++++++
 tb/tb_hw_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hw_ctrl.sv
// ---------------------------------------------------------------------------
// HwCtrl -- highway / farm-way junction controller
//
// The highway keeps GREEN for at least LONG_CYC cycles.  Once that minimum
// dwell has elapsed, a car waiting on the farm way starts a SHORT_CYC-cycle
// YELLOW, after which the highway goes RED.  On entry to RED the farm-way
// controller receives a one-cycle invk_fw grant.  The farm-way controller
// hands the junction back by asserting invk_hw, which returns the highway
// to GREEN.  If no hand-back arrives within RED_MAX cycles of RED, the
// sticky fault flag is raised.  The highway nevertheless stays RED until a
// hand-back arrives.
//
// Parameters
//   LONG_CYC  : minimum highway-green dwell in clk cycles (1..2^TW-1)
//   SHORT_CYC : highway-yellow dwell in clk cycles        (1..2^TW-1)
//   RED_MAX   : hand-back watchdog limit in clk cycles    (1..2^TW-1)
//   TW        : width of the internal dwell timer
//
// Ports
//   clk       in   clock, rising-edge active
//   reset     in   synchronous, active-high reset
//   car_on_fw in   farm-way car sensor (synchronous to clk)
//   invk_hw   in   hand-back from the farm-way controller (pulse or level)
//   invk_fw   out  registered 1-cycle pulse in the first RED cycle
//   hw_light  out  highway lamp: 0=RED, 1=GREEN, 2=YELLOW
//   fw_active out  high while the highway is RED
//   fault     out  sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module hw_ctrl #(
    parameter int LONG_CYC  = 16,
    parameter int SHORT_CYC = 4,
    parameter int RED_MAX   = 64,
    parameter int TW        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_on_fw,
    input  logic       invk_hw,
    output logic       invk_fw,
    output logic [1:0] hw_light,
    output logic       fw_active,
    output logic       fault
);

    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_RED    = 2'd2;

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_GREEN  = 2'd1;
    localparam logic [1:0] LIGHT_YELLOW = 2'd2;

    localparam logic [TW-1:0] GREEN_LIM  = TW'(LONG_CYC - 1);
    localparam logic [TW-1:0] YELLOW_LIM = TW'(SHORT_CYC - 1);
    localparam logic [TW-1:0] RED_LIM    = TW'(RED_MAX - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_lim;
    logic          green_done;
    logic          yellow_done;
    logic          red_return;
    logic          wd_expire;

    // The timer stops at the limit of whichever state we are in.  It must
    // never wrap, because the GREEN exit test and the watchdog test both
    // look for cnt sitting exactly on that limit.
    always_comb begin
        cnt_lim = GREEN_LIM;
        case (state)
            ST_YELLOW: cnt_lim = YELLOW_LIM;
            ST_RED:    cnt_lim = RED_LIM;
            default:   cnt_lim = GREEN_LIM;
        endcase
    end

    // Transition conditions.  Each condition is qualified by the state it
    // belongs to, so car_on_fw is only acted on in GREEN and invk_hw is only
    // acted on in RED.  Nothing is latched from the other states.  A
    // hand-back in the same cycle as the watchdog limit wins, so that cycle
    // does not count as an expiry.
    always_comb begin
        green_done  = (state == ST_GREEN)  && (cnt == GREEN_LIM) && car_on_fw;
        yellow_done = (state == ST_YELLOW) && (cnt == YELLOW_LIM);
        red_return  = (state == ST_RED)    && invk_hw;
        wd_expire   = (state == ST_RED)    && (cnt == RED_LIM) && !invk_hw;
    end

    // Next-state selection.  The three conditions are mutually exclusive
    // because each one requires a different current state.
    always_comb begin
        state_nxt = state;
        if (green_done) begin
            state_nxt = ST_YELLOW;
        end else if (yellow_done) begin
            state_nxt = ST_RED;
        end else if (red_return) begin
            state_nxt = ST_GREEN;
        end
    end

    // State, timer, grant pulse and sticky fault.
    // - The timer restarts at 0 whenever the state is about to change, so it
    //   reads 0 in the first cycle of every state.
    // - invk_fw is registered from the YELLOW exit, which makes it high in
    //   exactly the first RED cycle.
    // - fault is only ever set here; reset is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_GREEN;
            cnt     <= '0;
            invk_fw <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != cnt_lim) begin
                cnt <= cnt + 1'b1;
            end
            invk_fw <= yellow_done;
            if (wd_expire) begin
                fault <= 1'b1;
            end
        end
    end

    // The lamp and fw_active are decoded purely from the state register,
    // so no input reaches an output without first passing through a flop.
    always_comb begin
        hw_light = LIGHT_GREEN;
        case (state)
            ST_YELLOW: hw_light = LIGHT_YELLOW;
            ST_RED:    hw_light = LIGHT_RED;
            default:   hw_light = LIGHT_GREEN;
        endcase
        fw_active = (state == ST_RED);
    end

endmodule

// File: tb/tb_hw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hw_ctrl -- directed, table-driven bench for hw_ctrl (default parameters)
//
// Each table record is a segment: a fixed input pattern held for len cycles,
// together with the outputs expected in every cycle of that segment.
// Inputs are driven and outputs are sampled on the falling edge.  A record
// with rst=1 asserts reset for its cycles.  The outputs in such a cycle
// still show the pre-reset state; the cycle after the reset is cycle 0 of
// a new run.
// ---------------------------------------------------------------------------
module tb_hw_ctrl;

    typedef struct {
        int         len;
        logic       rst;
        logic       car;
        logic       invk;
        logic [1:0] light;
        logic       ifw;
        logic       fwa;
        logic       flt;
    } seg_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_on_fw = 1'b0;
    logic       invk_hw = 1'b0;
    logic       invk_fw;
    logic [1:0] hw_light;
    logic       fw_active;
    logic       fault;

    int assertCount = 0;
    int failCount   = 0;
    seg_t segs[$];

    always #5 clk = ~clk;

    hw_ctrl #(
        .LONG_CYC (16),
        .SHORT_CYC(4),
        .RED_MAX  (64),
        .TW       (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .car_on_fw(car_on_fw),
        .invk_hw  (invk_hw),
        .invk_fw  (invk_fw),
        .hw_light (hw_light),
        .fw_active(fw_active),
        .fault    (fault)
    );

    // Append one segment record to the table.
    function automatic void addSeg(input int len, input logic rst,
                                   input logic car, input logic invk,
                                   input logic [1:0] light, input logic ifw,
                                   input logic fwa, input logic flt);
        seg_t s;
        s.len = len; s.rst = rst; s.car = car; s.invk = invk;
        s.light = light; s.ifw = ifw; s.fwa = fwa; s.flt = flt;
        segs.push_back(s);
    endfunction

    // Compare one output against its expected value and count the result.
    task automatic checkOutput(input string name, input int segIdx,
                               input int step, input logic [1:0] act,
                               input logic [1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s seg %0d step %0d: got %0d, expected %0d",
                     name, segIdx, step, act, exp);
        end
    endtask

    // Drive one segment and check all four outputs in each of its cycles.
    task automatic applyStimulus(input int segIdx, input seg_t s);
        for (int i = 0; i < s.len; i++) begin
            @(negedge clk);
            reset     = s.rst;
            car_on_fw = s.car;
            invk_hw   = s.invk;
            checkOutput("hw_light",  segIdx, i, hw_light,         s.light);
            checkOutput("invk_fw",   segIdx, i, {1'b0, invk_fw},   {1'b0, s.ifw});
            checkOutput("fw_active", segIdx, i, {1'b0, fw_active}, {1'b0, s.fwa});
            checkOutput("fault",     segIdx, i, {1'b0, fault},     {1'b0, s.flt});
        end
    endtask

    initial begin
        // Argument order: len, rst, car, invk, light, invk_fw, fw_active, fault.
        // Light codes: 0 = RED, 1 = GREEN, 2 = YELLOW.

        // Power-on reset: outputs must show the reset state.
        addSeg(3, 1, 0, 0, 1, 0, 0, 0);

        // Basic cycle with a car waiting from cycle 0, then a hand-back at
        // cycle 25.  The new green needs the full 16 cycles.  A hand-back
        // in the very first RED cycle (46) returns to GREEN at once.
        addSeg(16, 0, 1, 0, 1, 0, 0, 0);
        addSeg(4,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  0, 1, 0, 0, 1, 1, 0);
        addSeg(4,  0, 1, 0, 0, 0, 1, 0);
        addSeg(1,  0, 1, 1, 0, 0, 1, 0);
        addSeg(16, 0, 1, 0, 1, 0, 0, 0);
        addSeg(4,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  0, 1, 1, 0, 1, 1, 0);
        addSeg(3,  0, 0, 0, 1, 0, 0, 0);
        addSeg(1,  1, 0, 0, 1, 0, 0, 0);

        // Late car: no car until cycle 40.  The car must not be acted on
        // once the highway is RED.
        addSeg(40, 0, 0, 0, 1, 0, 0, 0);
        addSeg(1,  0, 1, 0, 1, 0, 0, 0);
        addSeg(4,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  0, 1, 0, 0, 1, 1, 0);
        addSeg(4,  0, 0, 0, 0, 0, 1, 0);
        addSeg(1,  1, 0, 0, 0, 0, 1, 0);

        // Spurious hand-backs in GREEN (cycle 3) and YELLOW (cycle 17)
        // must leave the basic timing unchanged.
        addSeg(3,  0, 1, 0, 1, 0, 0, 0);
        addSeg(1,  0, 1, 1, 1, 0, 0, 0);
        addSeg(12, 0, 1, 0, 1, 0, 0, 0);
        addSeg(1,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  0, 1, 1, 2, 0, 0, 0);
        addSeg(2,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  0, 1, 0, 0, 1, 1, 0);
        addSeg(2,  0, 1, 0, 0, 0, 1, 0);
        addSeg(1,  1, 0, 0, 0, 0, 1, 0);

        // Reset in YELLOW at cycle 18.  The basic timing then restarts,
        // followed by a watchdog run: RED from cycle 20, fault from 84,
        // hand-back at 100, GREEN at 101 with the fault still set.
        addSeg(16, 0, 1, 0, 1, 0, 0, 0);
        addSeg(2,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  1, 1, 0, 2, 0, 0, 0);
        addSeg(16, 0, 1, 0, 1, 0, 0, 0);
        addSeg(4,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  0, 0, 0, 0, 1, 1, 0);
        addSeg(63, 0, 0, 0, 0, 0, 1, 0);
        addSeg(16, 0, 0, 0, 0, 0, 1, 1);
        addSeg(1,  0, 0, 1, 0, 0, 1, 1);
        addSeg(3,  0, 0, 0, 1, 0, 0, 1);
        addSeg(1,  1, 0, 0, 1, 0, 0, 1);

        // Hand-back on the watchdog limit cycle (83): return to GREEN with
        // no fault.  The car stays high through RED and is ignored.  Then a
        // full cycle, and a reset in RED that overrides a hand-back.
        addSeg(16, 0, 1, 0, 1, 0, 0, 0);
        addSeg(4,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  0, 1, 0, 0, 1, 1, 0);
        addSeg(62, 0, 1, 0, 0, 0, 1, 0);
        addSeg(1,  0, 1, 1, 0, 0, 1, 0);
        addSeg(16, 0, 1, 0, 1, 0, 0, 0);
        addSeg(4,  0, 1, 0, 2, 0, 0, 0);
        addSeg(1,  0, 1, 0, 0, 1, 1, 0);
        addSeg(1,  1, 1, 1, 0, 0, 1, 0);

        // A car seen only before green saturation (cycles 5-10) must not
        // shorten the green.  A car at cycle 21 starts YELLOW at 22, and
        // the car dropping during YELLOW is ignored.
        addSeg(5,  0, 0, 0, 1, 0, 0, 0);
        addSeg(6,  0, 1, 0, 1, 0, 0, 0);
        addSeg(10, 0, 0, 0, 1, 0, 0, 0);
        addSeg(1,  0, 1, 0, 1, 0, 0, 0);
        addSeg(4,  0, 0, 0, 2, 0, 0, 0);
        addSeg(1,  0, 0, 0, 0, 1, 1, 0);

        foreach (segs[k]) begin
            applyStimulus(k, segs[k]);
        end

        // Hand-written: reset held for several cycles with every other
        // input active.  The RED cycle in which reset is first applied
        // still shows RED; after that the outputs stay in the reset state.
        @(negedge clk);
        reset = 1'b1; car_on_fw = 1'b1; invk_hw = 1'b1;
        checkOutput("held_reset_entry_fw_active", 100, 0, {1'b0, fw_active}, 2'd1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("held_reset_light", 100, i, hw_light,         2'd1);
            checkOutput("held_reset_fault", 100, i, {1'b0, fault},   2'd0);
            checkOutput("held_reset_ifw",   100, i, {1'b0, invk_fw}, 2'd0);
        end

        // After release the green runs its full 16 cycles, then YELLOW.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            reset = 1'b0; invk_hw = 1'b0; car_on_fw = 1'b1;
            checkOutput("restart_light", 101, i, hw_light,
                        (i < 16) ? 2'd1 : 2'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
